// File: rtl/hc595_tx.sv
// hc595_tx: serialises a parallel word onto SER/SRCLK/RCLK pins of a
// 74HC595-style shift register and ends each frame with one latch pulse.
// Every pin is driven straight from a flop, so the external chip never sees
// combinational glitches.

module hc595_tx #(
    parameter int WIDTH     = 8,    // bits per frame, >= 1
    parameter int DIV       = 2,    // system clocks per SRCLK half-period, >= 1
    parameter bit MSB_FIRST = 1'b1  // 1: data_in[WIDTH-1] goes out first
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             ser,
    output logic             srclk,
    output logic             rclk
);

    // The bit counter must reach WIDTH itself, hence WIDTH+1 codes.
    localparam int CNT_W = $clog2(WIDTH + 1);
    // The divider counts 0..DIV-1; keep at least one bit so DIV=1 still elaborates.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t           state_reg,   state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] shreg_reg,   shreg_next;
    logic             ser_reg,     ser_next;
    logic             srclk_reg,   srclk_next;
    logic             rclk_reg,    rclk_next;
    logic             ready_reg,   ready_next;

    // The shift register holds only the bits not yet placed on ser. The head
    // bit is the next one to go out; "advance" drops the head and fills the
    // tail with zero. The same network is applied to data_in on accept, so
    // the first bit goes straight to ser and the rest wait in shreg_reg.
    logic [WIDTH-1:0] data_adv;
    logic [WIDTH-1:0] shreg_adv;
    logic             data_head;
    logic             shreg_head;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adv
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign data_adv[gi]  = 1'b0;
                    assign shreg_adv[gi] = 1'b0;
                end else begin : g_move
                    assign data_adv[gi]  = data_in[gi-1];
                    assign shreg_adv[gi] = shreg_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign data_adv[gi]  = 1'b0;
                    assign shreg_adv[gi] = 1'b0;
                end else begin : g_move
                    assign data_adv[gi]  = data_in[gi+1];
                    assign shreg_adv[gi] = shreg_reg[gi+1];
                end
            end
        end

        if (MSB_FIRST) begin : g_head_msb
            assign data_head  = data_in[WIDTH-1];
            assign shreg_head = shreg_reg[WIDTH-1];
        end else begin : g_head_lsb
            assign data_head  = data_in[0];
            assign shreg_head = shreg_reg[0];
        end
    endgenerate

    logic             div_last;
    logic [CNT_W-1:0] bit_inc;

    assign div_last = (div_cnt_reg == DIV_LAST);
    assign bit_inc  = bit_cnt_reg + 1'b1;

    // Next-state and next-pin logic; pins are registered below so each pin
    // changes exactly on the edge that enters its state.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        ser_next     = ser_reg;
        srclk_next   = 1'b0;
        rclk_next    = 1'b0;
        ready_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (valid && ready_reg) begin
                    // Accept: bit 0 appears on ser together with SHIFT_LO,
                    // which gives DIV cycles of setup before srclk rises.
                    state_next   = SHIFT_LO;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                    shreg_next   = data_adv;
                    ser_next     = data_head;
                    ready_next   = 1'b0;
                end
            end

            SHIFT_LO: begin
                if (div_last) begin
                    state_next   = SHIFT_HI;
                    div_cnt_next = '0;
                    srclk_next   = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            SHIFT_HI: begin
                srclk_next = 1'b1;
                if (div_last) begin
                    // Bit done: ser is held through the whole high phase and
                    // only moves on the falling srclk edge (hold = DIV cycles).
                    div_cnt_next = '0;
                    bit_cnt_next = bit_inc;
                    srclk_next   = 1'b0;
                    if (bit_inc == BIT_LAST) begin
                        state_next = LATCH;
                        rclk_next  = 1'b1;
                    end else begin
                        state_next = SHIFT_LO;
                        ser_next   = shreg_head;
                        shreg_next = shreg_adv;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            LATCH: begin
                rclk_next = 1'b1;
                if (div_last) begin
                    state_next   = IDLE;
                    div_cnt_next = '0;
                    rclk_next    = 1'b0;
                    ready_next   = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // State, counters, data and pin registers; reset aborts any frame in
    // flight without emitting an rclk pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            ser_reg     <= 1'b0;
            srclk_reg   <= 1'b0;
            rclk_reg    <= 1'b0;
            ready_reg   <= 1'b1;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            ser_reg     <= ser_next;
            srclk_reg   <= srclk_next;
            rclk_reg    <= rclk_next;
            ready_reg   <= ready_next;
        end
    end

    assign ready = ready_reg;
    assign ser   = ser_reg;
    assign srclk = srclk_reg;
    assign rclk  = rclk_reg;

endmodule

// File: doc/hc595_tx.md
# hc595_tx

Transmitter that drives a 74HC595-style serial-in/parallel-out receiver (SER, SRCLK, RCLK) from a parallel word. It is the write end of the shift-register output path in the logic-IC CPU. A word arrives over a valid/ready handshake, the block clocks it out bit by bit, and it finishes with one storage-latch pulse. All outputs are registered, so the external chip sees glitch-free pins.

## Interface
- WIDTH, default 8: bits per frame, ≥1.
- DIV, default 2: system clocks per SRCLK half-period, ≥1.
- MSB_FIRST, default 1: 1 shifts data_in[WIDTH-1] first, 0 shifts data_in[0] first.

- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- data_in  in  WIDTH  word to transmit. Sampled only on the accept cycle.
- valid  in  1  data_in is presented.
- ready  out  1  block is idle and can accept a word this cycle.
- ser  out  1  serial data to the receiver's SER pin.
- srclk  out  1  shift clock to the receiver; the receiver samples ser on the rising edge.
- rclk  out  1  storage-latch clock to the receiver; its rising edge transfers the shifted word.

## Operation
- States:
  - IDLE: ready=1, srclk=0, rclk=0, ser holds its last value.
  - SHIFT_LO: srclk=0, ser = current bit.
  - SHIFT_HI: srclk=1, ser held.
  - LATCH: rclk=1, srclk=0.
- Accept: valid & ready sampled high at a clk edge.
  - data_in is loaded into the shift register.
  - Bit counter is cleared.
  - Next state is SHIFT_LO.
  - ready drops on the same edge.
- SHIFT_LO: lasts DIV cycles, then goes to SHIFT_HI.
- SHIFT_HI: lasts DIV cycles. On exit the bit counter increments and the shift register advances. The direction follows MSB_FIRST.
  - Counter < WIDTH: go to SHIFT_LO with the next bit on ser.
  - Counter = WIDTH: go to LATCH.
- LATCH: lasts DIV cycles, then goes to IDLE.
- valid while ready=0 is ignored. Nothing is queued.
- data_in changes after accept have no effect on the frame in flight.
- Counter widths:
  - Bit counter: $clog2(WIDTH+1) bits.
  - Divider: $clog2(DIV) bits, minimum 1.
  - No wrap-around is possible within a frame.
- ser changes only on the edge that enters SHIFT_LO. This gives DIV cycles of setup before srclk rises and DIV cycles of hold after it.

## Timing
- Reset values, valid on the edge where rst=1:
  - ser=0, srclk=0, rclk=0, ready=1.
  - State=IDLE, counters 0.
- Reset mid-frame:
  - The frame is aborted on that edge. srclk and rclk are 0 from the next cycle on.
  - No rclk pulse is emitted, so the receiver's latched output is unchanged.
  - rst has priority over valid in the same cycle.
- Accept at edge T:
  - Bit 0 is on ser and srclk=0 from T through T+DIV.
  - First srclk rise is at T+DIV.
  - Bit k: srclk rises at T+(2k+1)·DIV.
  - rclk rises at T+2·WIDTH·DIV and is high for DIV cycles.
- Frame length:
  - ready is low for exactly 2·WIDTH·DIV + DIV cycles.
  - WIDTH=8, DIV=2 gives 34 cycles.
- Back-to-back: the first cycle with ready=1 can accept again. The minimum gap between frames is 1 IDLE cycle.
- Exactly WIDTH srclk rising edges and one rclk rising edge per completed frame.

## Test plan
- Reset:
  - Stimulus: rst high 3 cycles, with valid=1 during reset.
  - Required: ser=0, srclk=0, rclk=0, ready=1 after the first reset edge; no frame starts.
- Single frame, WIDTH=8, DIV=2, MSB_FIRST=1, data 0xA5:
  - Required: a behavioural 595 model shows 0xA5 on its parallel outputs after the rclk rise.
  - Required: 8 srclk rises, rclk high 2 cycles, ready low 34 cycles.
- LSB-first, data 0x01:
  - Required: ser=1 only during bit 0; model latches 0x01.
- Back-to-back, valid held high with 0x3C then 0xC3:
  - Stimulus: data_in changes mid-frame.
  - Required: second word accepted on the first ready cycle; model latches 0x3C, then 0xC3; mid-frame data_in changes are ignored.
- Reset mid-frame after 3 srclk rises:
  - Required: srclk=0, rclk=0, ready=1 on the next cycle; no rclk pulse; model latch retains its prior value.
- DIV=1, WIDTH=4, data 0x9:
  - Required: ready low 9 cycles, srclk rises at T+1, T+3, T+5, T+7, rclk high at T+8; model latches 0x9.
